fir_output_decimator: RTL
=========================

Name: fir_output_decimator

Overview:
Downstream stage of the FIR filter: consumes the filter's unsigned running-sum/product samples, block-averages DECIM accepted samples, then rounds and saturates the average to OUT_W bits. Results are buffered in a small FIFO and delivered on a valid/ready interface to the output pins or a serial/display driver. Sticky flags report saturation and FIFO overflow.

Parameters:
IN_W, 24, width of the unsigned input sample (filter accumulator width)
OUT_W, 8, width of the output sample
SHIFT, 8, extra right shift applied after averaging (selects output bits [SHIFT+OUT_W-1:SHIFT])
DECIM, 4, decimation factor; power of two, 1..16
DEPTH, 4, FIFO depth in entries; power of two, >=2

Ports:
clk  in  1  rising-edge clock
reset  in  1  synchronous, active-high reset
in_data  in  IN_W  unsigned sample from the filter
in_valid  in  1  in_data is valid this cycle (no backpressure; the input is always accepted)
out_data  out  OUT_W  FIFO head; 0 when FIFO empty
out_valid  out  1  FIFO not empty
out_ready  in  1  consumer takes the head when out_valid&out_ready
fifo_level  out  $clog2(DEPTH)+1  number of stored entries
sat_flag  out  1  sticky: a result was clipped
ovf_flag  out  1  sticky: a result was dropped because the FIFO was full
flag_clr  in  1  clears both sticky flags

Behaviour:
- Reset (sync, evaluated at clk edge, overrides everything): acc=0, phase=0, FIFO empty, rd/wr pointers 0, sat_flag=0, ovf_flag=0; hence out_valid=0, out_data=0, fifo_level=0. A reset mid-block discards the partial accumulation.
- Accumulator: width IN_W+log2(DECIM). On each cycle with in_valid=1: if phase<DECIM-1, acc<=acc+in_data and phase<=phase+1. Cycles with in_valid=0 leave acc and phase unchanged.
- Block completion: on the cycle with in_valid=1 and phase==DECIM-1: total=acc+in_data (combinational); acc<=0; phase<=0; the result is pushed at that same edge.
- Quantisation: S=SHIFT+log2(DECIM). If S>0, q=(total+2^(S-1))>>S (round half up; compute in IN_W+log2(DECIM)+1 bits so the carry is not lost); if S=0, q=total. If q>2^OUT_W-1, the result is 2^OUT_W-1 and sat_flag<=1; otherwise the result is q[OUT_W-1:0].
- Latency: the last sample of a block accepted at edge t gives out_valid=1 with that result from cycle t+1 when the FIFO was empty.
- Pop: when out_valid&out_ready, the head is removed at the edge. out_data shows the new head, or 0 if the FIFO is now empty.
- Push when not full: the entry is written and fifo_level increments, unless a pop happens on the same edge, in which case the level is unchanged.
- Push when full with a simultaneous pop: accepted. The level stays DEPTH and no overflow is flagged.
- Push when full with no pop: the result is dropped and ovf_flag<=1. FIFO contents and order are unchanged.
- Pop when empty: ignored (out_valid=0).
- Pointers wrap modulo DEPTH. Full is detected as fifo_level==DEPTH.
- Flags: sticky until flag_clr or reset. If flag_clr and a new set event happen in the same cycle, set wins (the flag reads 1 next cycle).
- in_data is unsigned. No signed handling is done.
- out_data is registered from FIFO storage; there is no combinational path from in_data to out_data.

Test Plan:
1. Defaults, out_ready=1, four samples 0x000100 with in_valid=1 -> the cycle after the 4th sample, out_valid=1 and out_data=0x01 for one cycle. sat_flag=0.
2. Rounding: four samples of 0x000080 -> out_data=0x01 (half rounds up). Four samples of 0x00007F -> out_data=0x00.
3. Saturation: four samples of 0xFFFFFF -> out_data=0xFF and sat_flag=1 stays set. Pulse flag_clr -> sat_flag=0 the next cycle.
4. in_valid gaps: samples 0x000400 on cycles 0, 3, 4, 9 (in_valid=0 elsewhere) -> exactly one result, 0x04, with out_valid rising the cycle after cycle 9.
5. Overflow: out_ready=0, push five blocks giving results 1,2,3,4,5 -> fifo_level=4, ovf_flag=1. Then out_ready=1 drains 1,2,3,4 in order and 5 is absent. Repeat with full FIFO and out_ready=1 on the push cycle -> the push is accepted and ovf_flag stays 0.
6. Reset mid-block: two samples 0xFFFFFF, then reset for one cycle, then four samples 0x000200 -> single output 0x02, with FIFO, level and flags all 0 immediately after the reset cycle.

Source files
------------

// File: rtl/fir_output_decimator.sv
// Block-averages DECIM filter samples, rounds/saturates to OUT_W bits and
// queues the results in a small FIFO behind a valid/ready output.
module fir_output_decimator #(
  parameter int IN_W  = 24,
  parameter int OUT_W = 8,
  parameter int SHIFT = 8,
  parameter int DECIM = 4,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [IN_W-1:0]          in_data,
  input  logic                     in_valid,
  output logic [OUT_W-1:0]         out_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [$clog2(DEPTH):0]   fifo_level,
  output logic                     sat_flag,
  output logic                     ovf_flag,
  input  logic                     flag_clr
);

  localparam int LD    = $clog2(DECIM);
  localparam int PW    = (LD > 0) ? LD : 1;
  localparam int AW    = IN_W + LD;
  localparam int S     = SHIFT + LD;
  localparam int QW    = (AW + 1 > OUT_W + 1) ? AW + 1 : OUT_W + 1;
  localparam int PTR_W = $clog2(DEPTH);

  localparam logic [PW-1:0]    LAST = PW'(DECIM - 1);
  localparam logic [QW-1:0]    RND  = (S > 0) ? (QW'(1) << ((S > 0) ? S - 1 : 0)) : '0;
  localparam logic [QW-1:0]    MAXV = (QW'(1) << OUT_W) - QW'(1);
  localparam logic [PTR_W:0]   FULL_LVL = (PTR_W + 1)'(DEPTH);

  logic [AW-1:0]      acc;
  logic [PW-1:0]      phase;
  logic [QW-1:0]      total;
  logic [QW-1:0]      q;
  logic               blk_done;
  logic               sat_now;
  logic [OUT_W-1:0]   result;

  logic [OUT_W-1:0]   mem [DEPTH];
  logic [PTR_W-1:0]   rd_ptr;
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W:0]     level;
  logic               full;
  logic               pop;
  logic               push_ok;
  logic               drop;

  assign blk_done = in_valid && (phase == LAST);
  // One extra bit of headroom so the rounding carry survives.
  assign total    = QW'(acc) + QW'(in_data);
  assign q        = (total + RND) >> S;
  assign sat_now  = (q > MAXV);
  assign result   = sat_now ? {OUT_W{1'b1}} : q[OUT_W-1:0];

  always_ff @(posedge clk) begin
    if (reset) begin
      acc   <= '0;
      phase <= '0;
    end else if (in_valid) begin
      if (blk_done) begin
        acc   <= '0;
        phase <= '0;
      end else begin
        acc   <= acc + AW'(in_data);
        phase <= phase + 1'b1;
      end
    end
  end

  assign full      = (level == FULL_LVL);
  assign out_valid = (level != '0);
  assign pop       = out_valid && out_ready;
  // A full FIFO still accepts a result when the head leaves on the same edge.
  assign push_ok   = blk_done && (!full || pop);
  assign drop      = blk_done && full && !pop;
  assign out_data  = out_valid ? mem[rd_ptr] : '0;
  assign fifo_level = level;

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= result;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      level  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sat_flag <= 1'b0;
      ovf_flag <= 1'b0;
    end else begin
      if (blk_done && sat_now) sat_flag <= 1'b1;
      else if (flag_clr)       sat_flag <= 1'b0;
      if (drop)                ovf_flag <= 1'b1;
      else if (flag_clr)       ovf_flag <= 1'b0;
    end
  end

endmodule
